serial_adder: RTL

- Parametrised multi-cycle adder/subtractor; the sequential successor to the combinational half/full adder cells in the arithmetic catalog.
- Operates on WIDTH-bit operands, DIGIT bits per clock, using one DIGIT-bit ripple slice plus a carry flip-flop.
- Valid/ready handshake on input and output; intended as a low-area arithmetic element for datapath experiments.

---
 rtl/serial_adder.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice plus a carry flop,
// walking WIDTH-bit operands LSB-first with valid/ready on both sides.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if (WIDTH < 2) begin : g_chk_width
         $error("serial_adder: WIDTH must be at least 2");
      end
      if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_chk_digit
         $error("serial_adder: DIGIT must divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  a_sh, b_sh, s_sh, s_nxt, sum_r;
   logic [CW-1:0]     count;
   logic              carry, cout_r, ovf_r;
   logic [DIGIT-1:0]  d_sum;
   logic              d_cout, c_msb, accept;

   // Ripple slice: the low digit of each shift register plus the carry flop.
   always_comb begin
      {d_cout, d_sum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry};
      c_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ d_sum[DIGIT-1];
      s_nxt = WIDTH'({d_sum, s_sh} >> DIGIT);
   end

   assign accept = (state == IDLE) && in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (count == LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         s_sh   <= '0;
         sum_r  <= '0;
         count  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + ~cin, so invert B and fold sub into the carry.
         a_sh  <= a;
         b_sh  <= sub ? ~b : b;
         carry <= cin ^ sub;
         count <= '0;
      end else if (state == BUSY) begin
         a_sh  <= a_sh >> DIGIT;
         b_sh  <= b_sh >> DIGIT;
         s_sh  <= s_nxt;
         carry <= d_cout;
         count <= count + 1'b1;
         if (count == LAST) begin
            sum_r  <= s_nxt;
            cout_r <= d_cout;
            ovf_r  <= c_msb ^ d_cout;
         end
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == BUSY);
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign overflow  = ovf_r;

endmodule
